mod9_check_arbiter: RTL and testbench

MOD9_CHECK_ARBITER -- requirements
Module: mod9_check_arbiter

---
 rtl/mod9_check_arbiter.sv | 139 +++++++++++++
 tb/tb_mod9_check_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod9_check_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mod9_check_arbiter: two-requester round-robin front end feeding a serial |
// | MSB-first mod-9 residue engine. Rev 1.0 - initial release.               |
// +--------------------------------------------------------------------------+
module mod9_check_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  input  logic             abort,
  output logic             res_valid,
  output logic             res_div,
  output logic [3:0]       res_rem,
  output logic             res_id,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_last;
  logic [WIDTH-1:0] r_sr;
  logic [3:0]       r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_owner;
  logic             r_res_valid;
  logic             r_res_div;
  logic [3:0]       r_res_rem;
  logic             r_res_id;

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_hs;
  logic [4:0]       w_dbl;
  logic [3:0]       w_sub;
  logic [3:0]       w_res_nxt;
  logic             w_last_bit;

  // r_last = 1 means requester 1 was granted last, so requester 0 wins a tie.
  assign w_gnt0     = req0_valid & (~req1_valid | r_last);
  assign w_gnt1     = req1_valid & (~req0_valid | ~r_last);
  assign req0_ready = rst & (r_state == IDLE) & w_gnt0;
  assign req1_ready = rst & (r_state == IDLE) & w_gnt1;
  assign w_hs       = req0_ready | req1_ready;

  // 2*res+bit <= 17 fits 5 bits; one conditional subtract keeps it in 0..8.
  assign w_dbl      = {r_res, r_sr[WIDTH-1]};
  assign w_sub      = w_dbl[3:0] - 4'd9;
  assign w_res_nxt  = (w_dbl >= 5'd9) ? w_sub : w_dbl[3:0];
  assign w_last_bit = (r_cnt == CW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_next = SHIFT;
      SHIFT: begin
        if (abort)           w_next = IDLE;
        else if (w_last_bit) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last      <= 1'b1;
      r_sr        <= '0;
      r_res       <= 4'd0;
      r_cnt       <= '0;
      r_owner     <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_div   <= 1'b0;
      r_res_rem   <= 4'd0;
      r_res_id    <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_sr    <= req1_ready ? req1_data : req0_data;
            r_res   <= 4'd0;
            r_cnt   <= CW'(WIDTH);
            r_owner <= req1_ready;
            r_last  <= req1_ready;
          end
        end
        SHIFT: begin
          if (!abort) begin
            r_sr  <= {r_sr[WIDTH-2:0], 1'b0};
            r_res <= w_res_nxt;
            r_cnt <= r_cnt - CW'(1);
          end
        end
        DONE: begin
          if (!abort) begin
            r_res_valid <= 1'b1;
            r_res_rem   <= r_res;
            r_res_div   <= (r_res == 4'd0);
            r_res_id    <= r_owner;
          end
        end
        default: begin
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign res_div   = r_res_div;
  assign res_rem   = r_res_rem;
  assign res_id    = r_res_id;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mod9_check_arbiter.sv
`default_nettype none
// Bench for mod9_check_arbiter: directed literal cases plus randomized traffic
// checked every cycle against a word-level model (value % 9, busy countdown).
module tb_mod9_check_arbiter;

  localparam int WIDTH = 8;
  localparam int BOUND = 2 * (WIDTH + 2);

  logic             clk;
  logic             rst;
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             abort;
  logic             res_valid;
  logic             res_div;
  logic [3:0]       res_rem;
  logic             res_id;
  logic             busy;

  mod9_check_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .abort      (abort),
    .res_valid  (res_valid),
    .res_div    (res_div),
    .res_rem    (res_rem),
    .res_id     (res_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word-level model: m_left counts cycles until the result appears.
  int       m_left = 0;
  int       m_data = 0;
  int       m_id   = 0;
  int       m_last = 1;
  int       m_rv   = 0;
  int       m_rem  = 0;
  int       m_div  = 0;
  int       m_rid  = 0;
  int       e_r0, e_r1;
  bit       rnd_phase = 0;
  int       wait0 = 0, wait1 = 0, max_wait = 0, n_results = 0;

  always @(negedge clk) begin
    if (!rst) begin
      m_left = 0; m_last = 1; m_rv = 0; m_rem = 0; m_div = 0; m_rid = 0;
      e_r0 = 0; e_r1 = 0;
    end else begin
      e_r0 = (m_left == 0 && req0_valid && (!req1_valid || m_last == 1)) ? 1 : 0;
      e_r1 = (m_left == 0 && req1_valid && (!req0_valid || m_last == 0)) ? 1 : 0;
    end
    check("req0_ready", int'(req0_ready), e_r0);
    check("req1_ready", int'(req1_ready), e_r1);
    check("busy",       int'(busy),       (m_left != 0) ? 1 : 0);
    check("res_valid",  int'(res_valid),  m_rv);
    check("res_rem",    int'(res_rem),    m_rem);
    check("res_div",    int'(res_div),    m_div);
    check("res_id",     int'(res_id),     m_rid);
    if (rnd_phase) begin
      if (req0_valid && !req0_ready) wait0++; else wait0 = 0;
      if (req1_valid && !req1_ready) wait1++; else wait1 = 0;
      if (wait0 > max_wait) max_wait = wait0;
      if (wait1 > max_wait) max_wait = wait1;
      if (res_valid) n_results++;
    end
    if (rst) begin
      m_rv = 0;
      if (m_left > 0) begin
        if (abort) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_rv  = 1;
            m_rem = m_data % 9;
            m_div = (m_data % 9 == 0) ? 1 : 0;
            m_rid = m_id;
          end
        end
      end else if (e_r0 || e_r1) begin
        m_id   = e_r1;
        m_data = e_r1 ? int'(req1_data) : int'(req0_data);
        m_last = e_r1;
        m_left = WIDTH + 1;
      end
    end
  end

  task automatic offer(input bit id, input logic [WIDTH-1:0] d);
    if (id) begin req1_valid = 1'b1; req1_data = d; end
    else    begin req0_valid = 1'b1; req0_data = d; end
  endtask

  // Returns at handshake edge + 2 with that requester's valid dropped.
  task automatic handshake(input bit id);
    bit got = 0;
    #1;
    for (int i = 0; i < 60; i++) begin
      if (id ? req1_ready : req0_ready) begin got = 1; break; end
      @(negedge clk);
    end
    check("handshake_timeout", int'(got), 1);
    @(posedge clk); #2;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [3:0] rem, output logic div,
                             output logic id, output int lat);
    bit got = 0;
    lat = 0; rem = 4'hF; div = 1'b0; id = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (res_valid) begin got = 1; rem = res_rem; div = res_div; id = res_id; break; end
    end
    check("result_timeout", int'(got), 1);
  endtask

  task automatic word(input string name, input bit id, input logic [WIDTH-1:0] d,
                      input int exp_rem, input int exp_div);
    logic [3:0] rem; logic div, rid; int lat;
    @(posedge clk); #2;
    offer(id, d);
    handshake(id);
    wait_result(rem, div, rid, lat);
    check({name, "_rem"}, int'(rem), exp_rem);
    check({name, "_div"}, int'(div), exp_div);
    check({name, "_id"},  int'(rid), int'(id));
    check({name, "_lat"}, lat, WIDTH + 1);
  endtask

  initial begin
    logic [3:0] rem; logic div, rid; int lat, pulses;
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_busy", int'(busy), 0);
    check("reset_rem",  int'(res_rem), 0);
    rst = 1'b1;

    word("w12", 1'b0, 8'h12, 0, 1);
    word("wFF", 1'b1, 8'hFF, 3, 0);
    word("w0A", 1'b1, 8'h0A, 1, 0);

    // Abort sampled at the edge ending the 4th SHIFT cycle.
    @(posedge clk); #2;
    offer(1'b0, 8'h1B);
    handshake(1'b0);
    repeat (3) @(posedge clk);
    #2 abort = 1'b1;
    @(posedge clk); #2 abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_rem",  int'(res_rem), 1);
    check("abort_div",  int'(res_div), 0);
    check("abort_id",   int'(res_id), 1);
    pulses = 0;
    repeat (15) begin @(negedge clk); if (res_valid) pulses++; end
    check("abort_pulses", pulses, 0);

    // Asynchronous reset mid-word.
    @(posedge clk); #2;
    offer(1'b1, 8'h33);
    handshake(1'b1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    req0_valid = 1'b1;
    #1;
    check("rst_busy",  int'(busy), 0);
    check("rst_rem",   int'(res_rem), 0);
    check("rst_id",    int'(res_id), 0);
    check("rst_valid", int'(res_valid), 0);
    check("rst_ready", int'(req0_ready), 0);
    repeat (2) @(posedge clk);
    #2 req0_valid = 1'b0; rst = 1'b1;

    // Tie after reset: requester 0 first, then 1, then 0 again.
    @(posedge clk); #2;
    offer(1'b0, 8'h09); offer(1'b1, 8'h00);
    #1;
    check("tie1_r0", int'(req0_ready), 1);
    check("tie1_r1", int'(req1_ready), 0);
    handshake(1'b0);
    wait_result(rem, div, rid, lat);
    check("tie_a_rem", int'(rem), 0);
    check("tie_a_div", int'(div), 1);
    check("tie_a_id",  int'(rid), 0);
    handshake(1'b1);
    wait_result(rem, div, rid, lat);
    check("tie_b_rem", int'(rem), 0);
    check("tie_b_div", int'(div), 1);
    check("tie_b_id",  int'(rid), 1);
    check("tie_b_lat", lat, WIDTH + 1);
    @(posedge clk); #2;
    offer(1'b0, 8'h05); offer(1'b1, 8'h06);
    #1;
    check("tie2_r0", int'(req0_ready), 1);
    check("tie2_r1", int'(req1_ready), 0);
    handshake(1'b0);
    req1_valid = 1'b0;
    wait_result(rem, div, rid, lat);
    check("tie_c_rem", int'(rem), 5);
    check("tie_c_id",  int'(rid), 0);

    word("w2D", 1'b0, 8'h2D, 0, 1);

    // Randomized traffic.
    @(posedge clk); #2;
    rnd_phase = 1;
    for (int c = 0; c < 10000; c++) begin
      if (!req0_valid || $urandom_range(0, 7) == 0) req0_valid = 1'($urandom_range(0, 1));
      if (!req1_valid || $urandom_range(0, 7) == 0) req1_valid = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: req0_data = '0;
        1: req0_data = '1;
        2, 3: req0_data = WIDTH'($urandom);
        default: ;
      endcase
      case ($urandom_range(0, 7))
        0: req1_data = '0;
        1: req1_data = '1;
        2, 3: req1_data = WIDTH'($urandom);
        default: ;
      endcase
      abort = ($urandom_range(0, 63) == 0);
      @(posedge clk); #2;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; abort = 1'b0;
    repeat (WIDTH + 4) @(posedge clk);
    #2 rnd_phase = 0;
    check("starvation_gap_ok", (max_wait <= BOUND) ? 1 : 0, 1);
    check("random_results_seen", (n_results > 200) ? 1 : 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
